// File: rtl/image_mem_arbiter_if.sv
// image_mem_arbiter_if
//   Bundles the two client ports and the RAM-side port of the image memory
//   arbiter.
//   Port A (display scan-out, read only): a_req, a_addr -> a_gnt, a_rdata, a_rvalid
//   Port B (processing/loader, read/write): b_req, b_we, b_addr, b_wdata
//                                           -> b_gnt, b_rdata, b_rvalid
//   RAM side: mem_we, mem_addr, mem_di -> RAM;  mem_do <- RAM (registered output)
//   Modports: slave  = arbiter view
//             master = environment view (clients plus RAM)
interface image_mem_arbiter_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 19
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_gnt;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rvalid;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_di;
  logic [DATA_W-1:0] mem_do;

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_do,
    output a_gnt, a_rdata, a_rvalid, b_gnt, b_rdata, b_rvalid,
           mem_we, mem_addr, mem_di
  );

  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_do,
    input  a_gnt, a_rdata, a_rvalid, b_gnt, b_rdata, b_rvalid,
           mem_we, mem_addr, mem_di
  );
endinterface

// File: rtl/image_mem_arbiter.sv
// image_mem_arbiter
//   Shares one single-port, write-first, 1-cycle-latency image RAM between a
//   display reader (port A, normally wins) and a read/write client (port B).
//   After FAIR_N consecutive A grants while B is waiting, B is given a slot.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : image_mem_arbiter_if.slave (client ports A/B plus RAM port)
// Grants are combinational (0-cycle latency); rvalid flags are registered and
// rdata is the RAM's registered output passed straight through.
module image_mem_arbiter #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned FAIR_N = 4
) (
  input  logic                clk,
  input  logic                reset,
  image_mem_arbiter_if.slave  bus
);

  localparam int unsigned   SW         = $clog2(FAIR_N + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(FAIR_N);

  logic [SW-1:0]     streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;

  logic              a_gnt, b_gnt;
  logic              mem_we;
  logic [DATA_W-1:0] mem_di;

  // Arbitration: A wins contention unless B has already lost FAIR_N times in a row.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      if (bus.a_req && bus.b_req) begin
        if (streak_q == STREAK_MAX) b_gnt = 1'b1;
        else                        a_gnt = 1'b1;
      end else begin
        a_gnt = bus.a_req;
        b_gnt = bus.b_req;
      end
    end
  end

  // Memory drive; when idle the address bus holds the last granted address.
  always_comb begin
    mem_we = 1'b0;
    mem_di = bus.b_wdata;
    addr_d = addr_q;
    if (a_gnt) begin
      addr_d = bus.a_addr;
    end else if (b_gnt) begin
      addr_d = bus.b_addr;
      mem_we = bus.b_we;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (b_gnt || !bus.b_req)                   streak_d = '0;
    else if (a_gnt && streak_q != STREAK_MAX)  streak_d = streak_q + SW'(1);
    a_rvalid_d = a_gnt;
    b_rvalid_d = b_gnt && !bus.b_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q   <= '0;
      addr_q     <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.mem_we   = mem_we;
  assign bus.mem_addr = addr_d;
  assign bus.mem_di   = mem_di;
  assign bus.a_rdata  = bus.mem_do;
  assign bus.b_rdata  = bus.mem_do;
  // rvalid is masked by reset so a read granted just before reset never
  // reports data, including in the first reset cycle itself.
  assign bus.a_rvalid = a_rvalid_q && !reset;
  assign bus.b_rvalid = b_rvalid_q && !reset;

endmodule

// File: doc/image_mem_arbiter.md
# image_mem_arbiter

Two-port arbiter that shares one single-port, write-first, 1-cycle-read-latency image RAM between a display scan-out reader (port A) and a processing/loader read-write client (port B). Port A normally wins. A streak counter guarantees port B one slot after every FAIR_N consecutive A grants under contention. The block sits directly in front of the pixel memory and owns its `we`/`addr`/`DI` inputs.

## Interface
- `DATA_W`, default 24: pixel/word width (RGB 8:8:8).
- `ADDR_W`, default 19: memory address width.
- `FAIR_N`, default 4: consecutive contended A grants before B is forced a slot. Legal range is ≥1.
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `a_req`  in  1: port A read request. Level; held while waiting.
- `a_addr`  in  ADDR_W: port A read address.
- `a_gnt`  out  1: port A request accepted this cycle (combinational).
- `a_rdata`  out  DATA_W: read data for port A. Qualified by `a_rvalid`.
- `a_rvalid`  out  1: `a_rdata` valid (registered).
- `b_req`  in  1: port B request.
- `b_we`  in  1: port B write (1) / read (0).
- `b_addr`  in  ADDR_W: port B address.
- `b_wdata`  in  DATA_W: port B write data.
- `b_gnt`  out  1: port B request accepted this cycle (combinational).
- `b_rdata`  out  DATA_W: read data for port B. Qualified by `b_rvalid`.
- `b_rvalid`  out  1: `b_rdata` valid; reads only (registered).
- `mem_we`  out  1: to RAM write enable.
- `mem_addr`  out  ADDR_W: to RAM address.
- `mem_di`  out  DATA_W: to RAM data in.
- `mem_do`  in  DATA_W: from RAM registered data out.

## Operation
- **Arbitration** (combinational, each cycle, not in reset):
  - Only `a_req` high: A wins.
  - Only `b_req` high: B wins.
  - Both high: B wins iff `streak == FAIR_N`; otherwise A wins.
  - Neither high: idle.
  - Exactly one of `a_gnt`/`b_gnt` may be high in any cycle.
- **Memory drive**:
  - A wins: `mem_addr = a_addr`, `mem_we = 0`.
  - B wins: `mem_addr = b_addr`, `mem_we = b_we`, `mem_di = b_wdata`.
  - Idle: `mem_we = 0`; `mem_addr` holds the last granted address (registered copy).
  - `mem_di` is don't-care whenever `mem_we = 0`.
- **Streak counter**, width clog2(FAIR_N+1), registered:
  - Increments when `a_gnt && b_req`.
  - Clears when `b_gnt`, or when `b_req` is low.
  - Never exceeds FAIR_N.
- **Read return**:
  - Registered flags `a_rvalid <= a_gnt` and `b_rvalid <= b_gnt && !b_we`.
  - `a_rdata = b_rdata = mem_do`, passed through combinationally.
  - `b_rvalid` stays low after a B write, even though the RAM echoes the write data.
- **Reset** (`reset` high at a rising edge):
  - `streak`, `a_rvalid`, `b_rvalid` and the held `mem_addr` all go to 0.
  - While `reset` is high: `a_gnt = b_gnt = mem_we = 0` and requests are ignored.
  - A read granted in the cycle before reset is asserted produces no `rvalid`.

## Timing
- Grant latency is 0 cycles: a request is granted in the same cycle its `req` is sampled high, if it wins.
- Read latency is 1 cycle. Grant in cycle N gives `rvalid` high in cycle N+1 with `mem_do` holding `mem[addr@N]`.
- Back-to-back grants give one access per cycle. Sustained throughput is 1 word/clock.
- Write completes at the rising edge ending the grant cycle.
- **Read-after-write**: a read to the same address granted in cycle N+1 returns the new data in N+2. This holds for either port.
- **Both requesting continuously**: grants follow A×FAIR_N, B×1, repeating. Worst-case B wait is FAIR_N cycles.
- A requester whose `req` drops without a grant is simply not served; no state is kept for it.
- Requesters hold `addr`/`we`/`wdata` stable until `gnt`.

## Test plan
- **Reset**: hold `reset` 3 cycles with `a_req = b_req = 1` → `a_gnt`, `b_gnt`, `mem_we` and both `rvalid` stay 0. First cycle after release: `a_gnt = 1`, `streak` starts at 0.
- **Single A read**: preload `mem[0x00010] = 0xABCDEF`; one-cycle `a_req` with `a_addr = 0x00010` → `a_gnt` in N; `a_rvalid = 1`, `a_rdata = 0xABCDEF` in N+1; `b_rvalid = 0`.
- **B write then A read**: B writes `0x123456` to `0x00020` in cycle N → `mem_we = 1` in N, `b_rvalid = 0` in N+1. A reads `0x00020` in N+1 → `a_rdata = 0x123456` in N+2.
- **Fairness**: `FAIR_N = 4`, both requests held 15 cycles → grant sequence AAAABAAAABAAAAB, never both grants in one cycle. Every B read returns `b_rvalid` exactly 1 cycle later.
- **Reset mid-operation**: A granted in N, `reset` high in N+1 → `a_rvalid = 0` in N+1 and N+2, `streak = 0`.
- **Idle address hold**: B granted at `0x7FFFF` (top address, wrap-free), then both requests low 5 cycles → `mem_addr` stays `0x7FFFF`, `mem_we = 0`, no `rvalid`.
